// File: rtl/mipi_align_ctrl_if.sv
`default_nettype none
// ============================================================================
//  mipi_align_ctrl_if
//  Bundle between the bit-shift search / framing logic and the word-alignment
//  lock controller.
//    enable       : synchronous run enable (low forces the controller to SEARCH)
//    sync_hit     : per-shift sync pattern hit pulses, one bit per candidate
//    shift_sel    : committed shift index for the datapath mux
//    locked       : alignment committed and healthy
//    row_start    : one-cycle qualified line-start pulse while locked
//    align_err    : one-cycle miss/timeout pulse while locked
//    relock_count : saturating count of lock losses
//  master = driver of enable/sync_hit, slave = the lock controller.
//  Revision: 1.0  initial release
// ============================================================================
interface mipi_align_ctrl_if #(
  parameter int NUM_SHIFT = 6
);
  logic                 enable;
  logic [NUM_SHIFT-1:0] sync_hit;
  logic [2:0]           shift_sel;
  logic                 locked;
  logic                 row_start;
  logic                 align_err;
  logic [7:0]           relock_count;

  modport master (
    output enable, sync_hit,
    input  shift_sel, locked, row_start, align_err, relock_count
  );

  modport slave (
    input  enable, sync_hit,
    output shift_sel, locked, row_start, align_err, relock_count
  );
endinterface
`default_nettype wire

// File: rtl/mipi_align_ctrl.sv
`default_nettype none
// ============================================================================
//  mipi_align_ctrl
//  Word-alignment lock controller for the single-lane CSI-2 deserializer.
//  Qualifies sync hits over several lines before committing a shift, then
//  supervises the committed alignment and drops back to search after
//  repeated misses or line timeouts.
//  Ports:
//    img_clk : pixel/word clock, rising edge
//    resetb  : asynchronous active-low reset
//    bus     : mipi_align_ctrl_if slave (enable, sync_hit in; shift_sel,
//              locked, row_start, align_err, relock_count out, all registered)
//  Revision: 1.0  initial release
// ============================================================================
module mipi_align_ctrl #(
  parameter int NUM_SHIFT    = 6,
  parameter int LOCK_HITS    = 4,
  parameter int LOSS_MISSES  = 3,
  parameter int LINE_TIMEOUT = 4000,
  parameter int CNT_W        = 12
) (
  input  wire logic          img_clk,
  input  wire logic          resetb,
  mipi_align_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] C_TIMEOUT   = CNT_W'(LINE_TIMEOUT);
  localparam logic [3:0]       C_LOCK_HITS = 4'(LOCK_HITS);
  localparam logic [3:0]       C_LOSS      = 4'(LOSS_MISSES);

  // Index of the lowest set bit; 0 when nothing is set.
  function automatic logic [2:0] lsb_idx(input logic [NUM_SHIFT-1:0] v);
    logic [2:0] r;
    r = 3'd0;
    for (int i = NUM_SHIFT - 1; i >= 0; i--) begin
      if (v[i]) r = 3'(i);
    end
    return r;
  endfunction

  // Bit select by a 3-bit index that stays safe for any NUM_SHIFT.
  function automatic logic bit_at(input logic [NUM_SHIFT-1:0] v, input logic [2:0] idx);
    logic r;
    r = 1'b0;
    for (int i = 0; i < NUM_SHIFT; i++) begin
      if (3'(i) == idx) r = v[i];
    end
    return r;
  endfunction

  state_t           state_q, state_d;
  logic [2:0]       cand_q, cand_d;
  logic [3:0]       hit_cnt_q, hit_cnt_d;
  logic [3:0]       miss_cnt_q, miss_cnt_d;
  logic [CNT_W-1:0] gap_q, gap_d;
  logic [2:0]       shift_sel_q, shift_sel_d;
  logic             locked_q, locked_d;
  logic             row_start_q, row_start_d;
  logic             align_err_q, align_err_d;
  logic [7:0]       relock_q, relock_d;

  logic       hit_any;
  logic [2:0] hit_lsb;
  logic       cand_match;
  logic       sel_match;
  logic       timeout;
  logic [3:0] hit_inc;
  logic [3:0] miss_inc;

  assign hit_any    = |bus.sync_hit;
  assign hit_lsb    = lsb_idx(bus.sync_hit);
  assign cand_match = bit_at(bus.sync_hit, cand_q);
  assign sel_match  = bit_at(bus.sync_hit, shift_sel_q);
  assign timeout    = (gap_q == C_TIMEOUT);
  assign hit_inc    = hit_cnt_q + 4'd1;
  assign miss_inc   = miss_cnt_q + 4'd1;

  always_comb begin
    state_d     = state_q;
    cand_d      = cand_q;
    hit_cnt_d   = hit_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    gap_d       = gap_q;
    shift_sel_d = shift_sel_q;
    locked_d    = locked_q;
    row_start_d = 1'b0;
    align_err_d = 1'b0;
    relock_d    = relock_q;

    if (!bus.enable) begin
      // shift_sel and relock_count deliberately survive a disable
      state_d    = ST_SEARCH;
      locked_d   = 1'b0;
      cand_d     = 3'd0;
      hit_cnt_d  = 4'd0;
      miss_cnt_d = 4'd0;
      gap_d      = '0;
    end else begin
      case (state_q)
        ST_SEARCH: begin
          gap_d = '0;
          if (hit_any) begin
            cand_d    = hit_lsb;
            hit_cnt_d = 4'd1;
            state_d   = ST_VERIFY;
          end
        end

        ST_VERIFY: begin
          gap_d = gap_q + CNT_W'(1);
          if (cand_match) begin
            hit_cnt_d = hit_inc;
            gap_d     = '0;
            if (hit_inc == C_LOCK_HITS) begin
              state_d     = ST_LOCKED;
              shift_sel_d = cand_q;
              locked_d    = 1'b1;
              miss_cnt_d  = 4'd0;
              hit_cnt_d   = 4'd0;
            end
          end else if (hit_any) begin
            // a different shift showed up: restart qualification on it
            cand_d    = hit_lsb;
            hit_cnt_d = 4'd1;
            gap_d     = '0;
          end else if (timeout) begin
            state_d   = ST_SEARCH;
            hit_cnt_d = 4'd0;
            gap_d     = '0;
          end
        end

        ST_LOCKED: begin
          gap_d = gap_q + CNT_W'(1);
          if (sel_match) begin
            // extra set bits alongside the committed one are tolerated
            row_start_d = 1'b1;
            miss_cnt_d  = 4'd0;
            gap_d       = '0;
          end else if (hit_any || timeout) begin
            align_err_d = 1'b1;
            miss_cnt_d  = miss_inc;
            gap_d       = '0;
            if (miss_inc == C_LOSS) begin
              state_d    = ST_SEARCH;
              locked_d   = 1'b0;
              miss_cnt_d = 4'd0;
              if (relock_q != 8'hFF) relock_d = relock_q + 8'd1;
            end
          end
        end

        default: begin
          state_d  = ST_SEARCH;
          locked_d = 1'b0;
          gap_d    = '0;
        end
      endcase
    end
  end

  always_ff @(posedge img_clk or negedge resetb) begin
    if (!resetb) begin
      state_q     <= ST_SEARCH;
      cand_q      <= 3'd0;
      hit_cnt_q   <= 4'd0;
      miss_cnt_q  <= 4'd0;
      gap_q       <= '0;
      shift_sel_q <= 3'd0;
      locked_q    <= 1'b0;
      row_start_q <= 1'b0;
      align_err_q <= 1'b0;
      relock_q    <= 8'd0;
    end else begin
      state_q     <= state_d;
      cand_q      <= cand_d;
      hit_cnt_q   <= hit_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      gap_q       <= gap_d;
      shift_sel_q <= shift_sel_d;
      locked_q    <= locked_d;
      row_start_q <= row_start_d;
      align_err_q <= align_err_d;
      relock_q    <= relock_d;
    end
  end

  assign bus.shift_sel    = shift_sel_q;
  assign bus.locked       = locked_q;
  assign bus.row_start    = row_start_q;
  assign bus.align_err    = align_err_q;
  assign bus.relock_count = relock_q;

endmodule
`default_nettype wire

// File: tb/tb_mipi_align_ctrl.sv
`default_nettype none
// ============================================================================
//  tb_mipi_align_ctrl
//  Directed bench for mipi_align_ctrl with a behavioural lock model and a
//  per-cycle output comparison, plus hand-computed literal expectations.
//  Revision: 1.0  initial release
// ============================================================================
module tb_mipi_align_ctrl;

  localparam int LT = 4000;
  localparam int LH = 4;
  localparam int LM = 3;

  localparam int HUNT = 0;
  localparam int QUAL = 1;
  localparam int LOCK = 2;

  logic img_clk = 1'b0;
  logic resetb  = 1'b0;
  always #5 img_clk = ~img_clk;

  mipi_align_ctrl_if #(.NUM_SHIFT(6)) bus ();

  mipi_align_ctrl #(
    .NUM_SHIFT   (6),
    .LOCK_HITS   (LH),
    .LOSS_MISSES (LM),
    .LINE_TIMEOUT(LT),
    .CNT_W       (12)
  ) dut (
    .img_clk (img_clk),
    .resetb  (resetb),
    .bus     (bus)
  );

  int checks   = 0;
  int failures = 0;

  // expected post-edge view of the controller
  int m_mode, m_cand, m_run, m_miss, m_idle, m_sel, m_relock;
  int m_locked, m_row, m_err;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int lowest(input logic [5:0] h);
    for (int i = 0; i < 6; i++) if (h[i]) return i;
    return 0;
  endfunction

  task automatic model_reset();
    m_mode = HUNT; m_cand = 0; m_run = 0; m_miss = 0; m_idle = 0;
    m_sel = 0; m_relock = 0; m_locked = 0; m_row = 0; m_err = 0;
  endtask

  // One sampled cycle of the lock rules.
  task automatic model_step(input bit en, input logic [5:0] h);
    m_row = 0;
    m_err = 0;
    if (!en) begin
      m_mode = HUNT; m_locked = 0; m_run = 0; m_miss = 0; m_idle = 0;
    end else if (m_mode == HUNT) begin
      if (h != 0) begin
        m_cand = lowest(h); m_run = 1; m_idle = 0; m_mode = QUAL;
      end
    end else if (m_mode == QUAL) begin
      if (h[m_cand]) begin
        m_run++; m_idle = 0;
        if (m_run == LH) begin
          m_mode = LOCK; m_sel = m_cand; m_locked = 1; m_miss = 0;
        end
      end else if (h != 0) begin
        m_cand = lowest(h); m_run = 1; m_idle = 0;
      end else if (m_idle == LT) begin
        m_mode = HUNT; m_idle = 0; m_run = 0;
      end else begin
        m_idle++;
      end
    end else begin
      if (h[m_sel]) begin
        m_row = 1; m_miss = 0; m_idle = 0;
      end else if (h != 0 || m_idle == LT) begin
        m_err = 1; m_miss++; m_idle = 0;
        if (m_miss == LM) begin
          m_mode = HUNT; m_locked = 0; m_miss = 0; m_run = 0;
          if (m_relock < 255) m_relock++;
        end
      end else begin
        m_idle++;
      end
    end
  endtask

  // Inputs change at the falling edge; the task returns at the next falling
  // edge, so outputs then reflect the sampled value.
  task automatic drive(input bit en, input logic [5:0] h);
    bus.enable   = en;
    bus.sync_hit = h;
    if (resetb) model_step(en, h);
    @(negedge img_clk);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b1, 6'h00);
  endtask

  task automatic lock_on(input logic [5:0] h);
    drive(1'b0, 6'h00);
    repeat (LH) drive(1'b1, h);
  endtask

  // per-cycle comparison against the model
  always @(posedge img_clk) begin
    #2;
    if (resetb) begin
      check("cyc_locked",    int'(bus.locked),       m_locked);
      check("cyc_shift_sel", int'(bus.shift_sel),    m_sel);
      check("cyc_row_start", int'(bus.row_start),    m_row);
      check("cyc_align_err", int'(bus.align_err),    m_err);
      check("cyc_relock",    int'(bus.relock_count), m_relock);
      check("cyc_excl",      int'(bus.row_start & bus.align_err), 0);
      check("cyc_row_nolock", int'(bus.row_start & ~bus.locked), 0);
    end
  end

  logic [5:0] seq2 [6];
  int n_err;

  initial begin
    seq2[0] = 6'h04; seq2[1] = 6'h04; seq2[2] = 6'h08;
    seq2[3] = 6'h08; seq2[4] = 6'h08; seq2[5] = 6'h08;
    bus.enable   = 1'b0;
    bus.sync_hit = 6'h00;
    model_reset();

    // reset state
    @(negedge img_clk);
    @(negedge img_clk);
    check("rst_locked",    int'(bus.locked),       0);
    check("rst_shift_sel", int'(bus.shift_sel),    0);
    check("rst_row_start", int'(bus.row_start),    0);
    check("rst_align_err", int'(bus.align_err),    0);
    check("rst_relock",    int'(bus.relock_count), 0);
    resetb = 1'b1;

    // lock on shift 2 with widely spaced hits
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 6'h04);
      if (k == 2) check("lock_not_yet", int'(bus.locked), 0);
      if (k < 3) idle(999);
    end
    check("lock_locked", int'(bus.locked), 1);
    check("lock_sel2",   int'(bus.shift_sel), 2);
    check("lock_no_row", int'(bus.row_start), 0);
    idle(999);
    drive(1'b1, 6'h04);
    check("fifth_row", int'(bus.row_start), 1);
    idle(1);
    check("fifth_row_pulse", int'(bus.row_start), 0);

    // candidate restart
    drive(1'b0, 6'h00);
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, seq2[k]);
      if (k == 4) check("restart_not_yet", int'(bus.locked), 0);
      idle(1);
    end
    check("restart_locked", int'(bus.locked), 1);
    check("restart_sel3",   int'(bus.shift_sel), 3);

    // multi-bit first hit picks the lowest set bit
    drive(1'b0, 6'h00);
    drive(1'b1, 6'b100110);
    check("multi_sel_held", int'(bus.shift_sel), 3);
    repeat (3) drive(1'b1, 6'b000010);
    check("multi_locked", int'(bus.locked), 1);
    check("multi_sel1",   int'(bus.shift_sel), 1);

    // loss by mismatch
    lock_on(6'h04);
    check("mm_sel2", int'(bus.shift_sel), 2);
    drive(1'b1, 6'h05);
    check("mm_extra_bits_row", int'(bus.row_start), 1);
    drive(1'b1, 6'h01);
    check("mm_err1", int'(bus.align_err), 1);
    drive(1'b1, 6'h01);
    drive(1'b1, 6'h04);
    check("mm_match_row", int'(bus.row_start), 1);
    drive(1'b1, 6'h01);
    drive(1'b1, 6'h01);
    check("mm_keep_lock", int'(bus.locked), 1);
    drive(1'b1, 6'h04);
    drive(1'b1, 6'h01);
    drive(1'b1, 6'h01);
    check("mm_still_lock", int'(bus.locked), 1);
    drive(1'b1, 6'h01);
    check("mm_lost",    int'(bus.locked), 0);
    check("mm_err3",    int'(bus.align_err), 1);
    check("mm_relock1", int'(bus.relock_count), 1);

    // timeout handling and loss by timeout
    lock_on(6'h04);
    idle(LT);
    drive(1'b1, 6'h04);
    check("to_hit_wins_row", int'(bus.row_start), 1);
    check("to_hit_wins_err", int'(bus.align_err), 0);
    idle(LT);
    check("to_not_yet", int'(bus.align_err), 0);
    idle(1);
    check("to_first_err", int'(bus.align_err), 1);
    n_err = 0;
    repeat (2 * (LT + 1)) begin
      drive(1'b1, 6'h00);
      if (bus.align_err) n_err++;
    end
    check("to_err_count", n_err, 2);
    check("to_last_err",  int'(bus.align_err), 1);
    check("to_lost",      int'(bus.locked), 0);
    check("to_relock2",   int'(bus.relock_count), 2);

    // enable low while locked
    lock_on(6'h08);
    check("en_locked", int'(bus.locked), 1);
    drive(1'b0, 6'h08);
    check("en_unlock", int'(bus.locked), 0);
    check("en_sel",    int'(bus.shift_sel), 3);
    check("en_relock", int'(bus.relock_count), 2);

    // asynchronous reset in the middle of verification
    drive(1'b1, 6'h04);
    drive(1'b1, 6'h04);
    check("ar_pre_sel", int'(bus.shift_sel), 3);
    #2;
    resetb = 1'b0;
    model_reset();
    #1;
    check("ar_locked",    int'(bus.locked),       0);
    check("ar_shift_sel", int'(bus.shift_sel),    0);
    check("ar_row_start", int'(bus.row_start),    0);
    check("ar_align_err", int'(bus.align_err),    0);
    check("ar_relock",    int'(bus.relock_count), 0);
    @(negedge img_clk);
    resetb = 1'b1;

    // relock counter saturation
    repeat (300) begin
      repeat (LH) drive(1'b1, 6'h01);
      repeat (LM) drive(1'b1, 6'h02);
    end
    check("sat_relock", int'(bus.relock_count), 255);
    check("sat_unlocked", int'(bus.locked), 0);

    idle(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
